// File: rtl/alephminer_result_packer.sv
// Result packer: captures one hash-core result record, requests a slot write and streams it
// out word by word. Define ALEPHMINER_PACKER_TIMEOUT_EN to add the WAIT_B watchdog.
module alephminer_result_packer #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_RESULT_WIDTH     = 512,
  parameter int unsigned C_NUM_SLOTS        = 16,
  parameter int unsigned C_TIMEOUT          = 65535
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [C_RESULT_WIDTH-1:0]     res_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  output logic                          ctrl_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                          Vld_O,
  input  logic                          Rdy_I,
  output logic [C_M_AXI_DATA_WIDTH-1:0] Data_O,
  input  logic                          BVld_I,
  output logic                          busy,
  output logic [31:0]                   result_count,
  output logic                          err
);

  localparam int unsigned NWORDS = C_RESULT_WIDTH / C_M_AXI_DATA_WIDTH;
  localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned SW     = (C_NUM_SLOTS > 1) ? $clog2(C_NUM_SLOTS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [SW-1:0]  LAST_SLOT = SW'(C_NUM_SLOTS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_WAIT_B = 2'd3;

  if (!(C_M_AXI_DATA_WIDTH == 32 || C_M_AXI_DATA_WIDTH == 64 || C_M_AXI_DATA_WIDTH == 128 ||
        C_M_AXI_DATA_WIDTH == 256 || C_M_AXI_DATA_WIDTH == 512)) begin : g_bad_dw
    $error("C_M_AXI_DATA_WIDTH must be 32, 64, 128, 256 or 512");
  end
  if (NWORDS == 0 || (C_RESULT_WIDTH % C_M_AXI_DATA_WIDTH) != 0) begin : g_bad_rw
    $error("C_RESULT_WIDTH must be a non-zero multiple of C_M_AXI_DATA_WIDTH");
  end
  if (C_NUM_SLOTS == 0 || (C_NUM_SLOTS & (C_NUM_SLOTS - 1)) != 0) begin : g_bad_slots
    $error("C_NUM_SLOTS must be a power of two");
  end
  if (C_TIMEOUT == 0) begin : g_bad_tmo
    $error("C_TIMEOUT must be non-zero");
  end

  logic [1:0]                state;
  logic [WCW-1:0]            word_cnt;
  logic [SW-1:0]             slot_idx;
  logic [C_RESULT_WIDTH-1:0] shreg;
  logic                      wd_expire;

`ifdef ALEPHMINER_PACKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  // Counter sits at zero outside WAIT_B, so it is already cleared on entry.
  assign wd_expire = (state == S_WAIT_B) && !BVld_I && (wd_cnt == TW'(C_TIMEOUT - 1));

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT_B) ? wd_cnt + 1'b1 : '0;
      if (wd_expire) err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state            <= S_IDLE;
      word_cnt         <= '0;
      slot_idx         <= '0;
      result_count     <= '0;
      ctrl_addr_offset <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (res_valid) begin
            ctrl_addr_offset <= base_addr + (C_M_AXI_ADDR_WIDTH'(slot_idx) << 12);
            word_cnt         <= '0;
            state            <= S_START;
          end
        end
        S_START: state <= S_STREAM;
        S_STREAM: begin
          if (Rdy_I) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (BVld_I) begin
            result_count <= result_count + 32'd1;
            slot_idx     <= (slot_idx == LAST_SLOT) ? '0 : slot_idx + 1'b1;
            state        <= S_IDLE;
          end else if (wd_expire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath register needs no reset: it is always reloaded on accept.
  always_ff @(posedge aclk) begin
    if (state == S_IDLE && res_valid)
      shreg <= res_data;
    else if (state == S_STREAM && Rdy_I)
      shreg <= shreg >> C_M_AXI_DATA_WIDTH;
  end

  assign res_ready               = (state == S_IDLE) && areset;
  assign ctrl_start              = (state == S_START);
  assign Vld_O                   = (state == S_STREAM);
  assign Data_O                  = shreg[C_M_AXI_DATA_WIDTH-1:0];
  assign busy                    = (state != S_IDLE);
  assign ctrl_xfer_size_in_bytes = C_M_AXI_ADDR_WIDTH'(C_RESULT_WIDTH / 8);

endmodule

// File: doc/alephminer_result_packer.md
ALEPHMINER_RESULT_PACKER -- requirements
Module: alephminer_result_packer

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 64, is the address width of ctrl_addr_offset and base_addr.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, is the stream word width; legal values are 32, 64, 128, 256 and 512.
REQ-003 Parameter C_RESULT_WIDTH, default 512, is the result record width and SHALL be an integer multiple of C_M_AXI_DATA_WIDTH.
REQ-004 Parameter C_NUM_SLOTS, default 16, is the number of 4096-byte result slots and SHALL be a power of two.
REQ-005 Parameter C_TIMEOUT, default 65535, is the WAIT_B watchdog limit in cycles.
REQ-006 aclk  in  1  single clock; every sequential element is clocked on the rising edge.
REQ-007 areset  in  1  reset, asynchronous, active-low.
REQ-008 res_valid, res_ready, res_data  in/out/in  1/1/C_RESULT_WIDTH  result handshake from the hash core.
REQ-009 base_addr  in  C_M_AXI_ADDR_WIDTH  result buffer base address, 4 KiB aligned, sampled at result accept.
REQ-010 ctrl_start  out  1  one-cycle start pulse to the write master.
REQ-011 ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  slot address presented to the write master.
REQ-012 ctrl_xfer_size_in_bytes  out  C_M_AXI_ADDR_WIDTH  constant value C_RESULT_WIDTH/8.
REQ-013 Vld_O, Rdy_I, Data_O  out/in/out  1/1/C_M_AXI_DATA_WIDTH  stream to the write master.
REQ-014 BVld_I  in  1  write-response pulse from the write master.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 result_count  out  32  number of completed result writes, wrapping.
REQ-017 err  out  1  sticky watchdog error flag.

Function
REQ-018 The FSM SHALL have four states: IDLE, START, STREAM and WAIT_B.
REQ-019 IDLE: res_ready=1; when res_valid=1, capture res_data into the shift register, set ctrl_addr_offset = base_addr + slot_idx*4096 and go to START.
REQ-020 In every state other than IDLE, res_ready=0.
REQ-021 START: ctrl_start=1 for exactly this one cycle, then go to STREAM.
REQ-022 STREAM: Vld_O=1; Data_O = the low C_M_AXI_DATA_WIDTH bits of the shift register, so word 0 = res_data[DW-1:0] and words go out in ascending order.
REQ-023 When Vld_O & Rdy_I, shift right by DW and increment the word counter; after word N-1 (N = C_RESULT_WIDTH/DW), go to WAIT_B with Vld_O=0 in the next cycle.
REQ-024 Data_O and Vld_O SHALL be held stable while Vld_O=1 and Rdy_I=0; Vld_O SHALL never depend combinationally on Rdy_I.
REQ-025 WAIT_B: on BVld_I=1, increment result_count and increment slot_idx modulo C_NUM_SLOTS, then go to IDLE.
REQ-026 BVld_I seen in IDLE, START or STREAM SHALL be ignored with no counter change.
REQ-027 ctrl_addr_offset SHALL be held stable from START through WAIT_B.
REQ-028 Latency SHALL be res accept to ctrl_start = 1 cycle; a new result may be accepted in the cycle after the BVld_I cycle.
REQ-029 result_count SHALL wrap from 0xFFFFFFFF to 0; slot_idx SHALL wrap from C_NUM_SLOTS-1 to 0.

Reset
REQ-030 areset=0 SHALL immediately force state IDLE and clear slot_idx, result_count, the word counter and err.
REQ-031 While in reset, ctrl_start=0, Vld_O=0, busy=0 and res_ready=0, regardless of clock activity.
REQ-032 Reset mid-STREAM or mid-WAIT_B SHALL abandon the record; the first result after reset SHALL go to slot 0.

Configuration
REQ-033 Macro ALEPHMINER_PACKER_TIMEOUT_EN enables the WAIT_B watchdog.
REQ-034 With the macro defined: a cycle counter clears on WAIT_B entry; if it reaches C_TIMEOUT without BVld_I, set err=1, return to IDLE, and leave result_count and slot_idx unchanged.
REQ-035 Without the macro: WAIT_B waits indefinitely, err is tied to 0, and no watchdog counter is synthesised.

Verification
REQ-036 Default parameters, base_addr=0x1000_0000, one result with Rdy_I=1 -> one ctrl_start pulse, ctrl_addr_offset=0x1000_0000, size=64, 16 words in order; after BVld_I, result_count=1.
REQ-037 Seventeen back-to-back results -> slot addresses 0x1000_0000 through 0x1000_F000, then 0x1000_0000 again; result_count=17.
REQ-038 Rdy_I toggled pseudo-randomly at 50% -> Data_O stable under backpressure; exactly 16 accepted beats per record, matching res_data.
REQ-039 res_valid held high during STREAM -> res_ready=0; the second record is accepted only after BVld_I.
REQ-040 areset pulsed low after word 7 -> outputs cleared within the reset; the next result writes slot 0 with 16 fresh words.
REQ-041 ALEPHMINER_PACKER_TIMEOUT_EN defined, C_TIMEOUT=100, BVld_I withheld -> err=1 after 100 WAIT_B cycles, state IDLE, result_count unchanged.
